// File: rtl/vertex_transform_unit.sv
// vertex_transform_unit
//   Streams signed 3-D vertices (w = 1 implied) through a programmable 4x4
//   fixed-point matrix. Each of the x/y/z rows is a dot product that is
//   scaled by 2^-FRAC_SHIFT and clamped to OUT_W-bit signed range.
//   Two register stages: S1 = products + side-band, S2 = sum/shift/sat.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mat_we/mat_addr/mat_wdata coefficient write, row-major index r*4+c
//   in_valid/in_ready        input handshake; in_ready = ~stall
//   in_x/in_y/in_z, in_last  vertex components and batch marker
//   out_valid/out_ready      output handshake
//   out_x/out_y/out_z        transformed, saturated components
//   out_sat                  any component of this vertex clamped
//   out_last                 delayed in_last

// One matrix row: S1 holds the four products, S2 holds the clamped result.
module vtu_row #(
  parameter int IN_W       = 14,
  parameter int OUT_W      = 11,
  parameter int FRAC_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3:0][IN_W-1:0] coef,
  input  logic [IN_W-1:0]      vx,
  input  logic [IN_W-1:0]      vy,
  input  logic [IN_W-1:0]      vz,
  output logic [OUT_W-1:0]     res,
  output logic                 sat
);
  localparam int PW = 2*IN_W;
  // Two guard bits cover the four-term sum with no overflow.
  localparam int AW = PW + 2;

  logic signed [PW-1:0] prod [4];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] scl;
  logic                 fits;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) prod[i] <= '0;
    end else if (en) begin
      prod[0] <= PW'($signed(coef[0])) * PW'($signed(vx));
      prod[1] <= PW'($signed(coef[1])) * PW'($signed(vy));
      prod[2] <= PW'($signed(coef[2])) * PW'($signed(vz));
      // w = 1, so the translation term is just the sign-extended coefficient
      prod[3] <= PW'($signed(coef[3]));
    end
  end

  always_comb begin
    acc  = AW'(prod[0]) + AW'(prod[1]) + AW'(prod[2]) + AW'(prod[3]);
    scl  = acc >>> FRAC_SHIFT;
    // Value fits in OUT_W bits iff all bits from the OUT_W sign bit up agree.
    fits = (&scl[AW-1:OUT_W-1]) | ~(|scl[AW-1:OUT_W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      sat <= 1'b0;
    end else if (en) begin
      // Clamp: negative -> 100..0 (min), positive -> 011..1 (max)
      res <= fits ? scl[OUT_W-1:0] : {scl[AW-1], {(OUT_W-1){~scl[AW-1]}}};
      sat <= ~fits;
    end
  end
endmodule

module vertex_transform_unit #(
  parameter int IN_W       = 14,
  parameter int OUT_W      = 11,
  parameter int FRAC_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mat_we,
  input  logic [3:0]       mat_addr,
  input  logic [IN_W-1:0]  mat_wdata,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  input  logic [IN_W-1:0]  in_y,
  input  logic [IN_W-1:0]  in_z,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_x,
  output logic [OUT_W-1:0] out_y,
  output logic [OUT_W-1:0] out_z,
  output logic             out_sat,
  output logic             out_last
);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;

  logic [15:0][IN_W-1:0]              mat;
  logic [STAGES:1]                    vld_q;
  logic [STAGES:0]                    vld_pipe;
  logic [STAGES:1]                    last_q;
  logic                               stall;
  logic                               adv;
  logic [NUM_LANES-1:0][OUT_W-1:0]    res;
  logic [NUM_LANES-1:0]               sat;
  logic                               unused_w;

  // Row 3 is programmable but does not feed the output.
  assign unused_w = ^mat[15:12];

  assign vld_pipe  = {vld_q, in_valid};
  assign stall     = vld_q[STAGES] & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign out_last  = last_q[STAGES];
  assign out_sat   = |sat;
  assign out_x     = res[0];
  assign out_y     = res[1];
  assign out_z     = res[2];

  // A vertex captured on the same edge as a write reads the old value,
  // since S1 samples mat before the write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mat[i] <= (i % 5 == 0) ? IN_W'(16) : '0;
    end else if (mat_we) begin
      mat[mat_addr] <= mat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (adv) begin
      vld_q  <= vld_pipe[STAGES-1:0];
      last_q <= {last_q[STAGES-1:1], in_last};
    end
  end

  for (genvar r = 0; r < NUM_LANES; r++) begin : g_row
    vtu_row #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .FRAC_SHIFT(FRAC_SHIFT)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .coef(mat[r*4 +: 4]),
      .vx  (in_x),
      .vy  (in_y),
      .vz  (in_z),
      .res (res[r]),
      .sat (sat[r])
    );
  end
endmodule

// File: tb/tb_vertex_transform_unit.sv
module tb_vertex_transform_unit;
  logic        clk = 0;
  logic        rst;
  logic        mat_we;
  logic [3:0]  mat_addr;
  logic [13:0] mat_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_x, in_y, in_z;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_x, out_y, out_z;
  logic        out_sat;
  logic        out_last;

  typedef struct {
    int x, y, z;
    bit sat, last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vertex_transform_unit dut (
    .clk(clk), .rst(rst),
    .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_sat(out_sat), .out_last(out_last)
  );

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every completed output handshake and
  // checks held outputs against the queue head while stalled.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output x=%0d y=%0d z=%0d",
                 $signed(out_x), $signed(out_y), $signed(out_z));
      end else begin
        chk("out_x",    int'($signed(out_x)), q[0].x);
        chk("out_y",    int'($signed(out_y)), q[0].y);
        chk("out_z",    int'($signed(out_z)), q[0].z);
        chk("out_sat",  int'(out_sat),  int'(q[0].sat));
        chk("out_last", int'(out_last), int'(q[0].last));
        if (out_ready) void'(q.pop_front());
        else chk("stall_in_ready", int'(in_ready), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int val);
    mat_we    = 1;
    mat_addr  = 4'(addr);
    mat_wdata = 14'(val);
    tick();
    mat_we    = 0;
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c, input int d);
    wr(r*4+0, a); wr(r*4+1, b); wr(r*4+2, c); wr(r*4+3, d);
  endtask

  task automatic set_identity();
    set_row(0, 16, 0, 0, 0); set_row(1, 0, 16, 0, 0);
    set_row(2, 0, 0, 16, 0); set_row(3, 0, 0, 0, 16);
  endtask

  // Present one vertex, wait (bounded) for acceptance, optionally push expected.
  task automatic send(input int x, input int y, input int z, input bit last,
                      input bit push, input int ex, input int ey, input int ez, input bit es);
    bit acc = 0;
    int n   = 0;
    exp_t e;
    in_valid = 1;
    in_x = 14'(x); in_y = 14'(y); in_z = 14'(z); in_last = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 0;
    in_last  = 0;
    if (!acc) chk("accept_timeout", 0, 1);
    else if (push) begin
      e.x = ex; e.y = ey; e.z = ez; e.sat = es; e.last = last;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1; mat_we = 0; mat_addr = 0; mat_wdata = 0;
    in_valid = 0; in_x = 0; in_y = 0; in_z = 0; in_last = 0; out_ready = 1;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_x",     int'(out_x), 0);
    chk("rst_out_y",     int'(out_y), 0);
    chk("rst_out_z",     int'(out_z), 0);
    chk("rst_out_sat",   int'(out_sat), 0);
    chk("rst_out_last",  int'(out_last), 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    tick();

    // Identity pass-through and two-cycle latency
    send(100, -50, 7, 0, 1, 100, -50, 7, 0);
    @(negedge clk);
    chk("lat_cycle1_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_valid", int'(out_valid), 1);
    tick();
    drain();

    // Programmed matrix, back-to-back
    set_row(0, 5, -3, -5, 0); set_row(1, 2, 7, -2, 0);
    set_row(2, 5, 0, 5, 0);   set_row(3, 0, 0, 0, 8);
    send(16, 0, 0, 0, 1,  5,  2, 5, 0);
    send(0, 16, 0, 0, 1, -3,  7, 0, 0);
    send(0, 0, 16, 0, 1, -5, -2, 5, 0);
    drain();

    // Rounding toward -inf and translation
    set_row(0, 1, 0, 0, 160); set_row(1, 0, 0, 0, 0);
    set_row(2, 0, 0, 0, 0);   set_row(3, 0, 0, 0, 0);
    send(-1,   0, 0, 0, 1,  9, 0, 0, 0);
    send(-161, 0, 0, 0, 1, -1, 0, 0, 0);
    send(15,   0, 0, 0, 1, 10, 0, 0, 0);
    drain();

    // Saturation edges
    set_identity();
    send(2000, -2000, 0, 0, 1, 1023, -1024, 0, 1);
    send(1023, -1024, 0, 0, 1, 1023, -1024, 0, 0);
    send(1024, -1025, 5, 0, 1, 1023, -1024, 5, 1);
    send(-3, 0, 1024, 0, 1, -3, 0, 1023, 1);
    drain();

    // Backpressure: 3-cycle stall mid-stream, last on the 6th vertex
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(i*10+1, -(i*7), i, (i == 5), 1, i*10+1, -(i*7), i, 0);
      end
      begin
        repeat (3) tick();
        out_ready = 0;
        repeat (3) tick();
        out_ready = 1;
      end
    join
    drain();

    // Write coherence: same-cycle write uses old coefficient
    mat_we = 1; mat_addr = 0; mat_wdata = 14'd32;
    in_valid = 1; in_x = 14'd10; in_y = 0; in_z = 0; in_last = 0;
    @(negedge clk);
    chk("coh_in_ready", int'(in_ready), 1);
    e.x = 10; e.y = 0; e.z = 0; e.sat = 0; e.last = 0;
    q.push_back(e);
    tick();
    mat_we = 0; in_valid = 0;
    send(10, 0, 0, 0, 1, 20, 0, 0, 0);
    drain();

    // Mid-stream reset with two vertices in flight; reset beats a write
    send(1, 1, 1, 0, 0, 0, 0, 0, 0);
    send(2, 2, 2, 0, 0, 0, 0, 0, 0);
    rst = 1; mat_we = 1; mat_addr = 0; mat_wdata = 14'd48;
    tick();
    mat_we = 0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_x",     int'(out_x), 0);
    chk("midrst_out_last",  int'(out_last), 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    repeat (6) tick();
    send(3, 4, 5, 1, 1, 3, 4, 5, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
